// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler: double-buffered 16-channel PWM config scheduler with prescaler and 8-bit period counter
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_0..cfg_4        SPI bank: out-enable lo/hi, pwm-enable lo/hi, duty
//   freeze              holds the active config, blocks commits
//   pwm_out             registered pin drive
//   active_duty         committed duty
//   pending             staged config differs from active
//   commit              1-cycle pulse in the first cycle of a period that took new config
//   period_start        1-cycle pulse in the first cycle of every period
module pwm_cfg_scheduler #(
  parameter int PRESCALE = 13,
  parameter int PRE_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cfg_0,
  input  logic [7:0]  cfg_1,
  input  logic [7:0]  cfg_2,
  input  logic [7:0]  cfg_3,
  input  logic [7:0]  cfg_4,
  input  logic        freeze,
  output logic [15:0] pwm_out,
  output logic [7:0]  active_duty,
  output logic        pending,
  output logic        commit,
  output logic        period_start
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PEND   = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;
  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt;
  logic [39:0]      staged, active;
  logic [1:0]       state, state_nx;
  logic             tick, boundary, diff, do_commit, lvl;
  assign tick        = pre_cnt == PRE_W'(PRESCALE - 1);
  assign boundary    = tick && pwm_cnt == 8'hFF;
  assign diff        = staged != active;
  assign active_duty = active[39:32];
  assign pending     = state != IDLE;
  assign lvl         = (active[39:32] == 8'hFF) || (pwm_cnt < active[39:32]);
  // freeze outranks the boundary; a cleared diff drops straight back to IDLE from any state
  assign do_commit   = state == PEND && diff && !freeze && boundary;
  always_comb begin
    state_nx = !diff ? IDLE : freeze ? FROZEN : do_commit ? IDLE : PEND;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      staged       <= '0;
      active       <= '0;
      state        <= IDLE;
      pwm_out      <= '0;
      commit       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt      <= tick ? pwm_cnt + 8'd1 : pwm_cnt;
      staged       <= {cfg_4, cfg_3, cfg_2, cfg_1, cfg_0};
      active       <= do_commit ? staged : active;
      state        <= state_nx;
      pwm_out      <= active[15:0] & (~active[31:16] | {16{lvl}});
      commit       <= do_commit;
      period_start <= boundary;
    end
  end
endmodule
